paddle_adc_conditioner: RTL and testbench
=========================================

Name: paddle_adc_conditioner

Overview:
- Multi-channel analog paddle front end: turns raw ADC conversion frames into signed paddle positions for the console core's paddle inputs.
- Successor to the fixed two-channel clamp-and-scale logic in the top level. Adds:
  - parametrised channel count and widths;
  - runtime or auto-tracked calibration window;
  - per-channel inversion;
  - IIR smoothing;
  - a time-multiplexed serial divider instead of a combinational divide.
- Sits between the ADC interface and the paddle mux in the emu top.

Parameters:
- CHANNELS, 4, number of analog channels; each frame carries one sample per channel.
- ADC_W, 12, raw sample width.
- OUT_W, 8, output width (signed).
- DEF_LO, 300, default lower clamp bound, in ADC codes.
- DEF_HI, 1500, default upper clamp bound, in ADC codes.
- MIN_SPAN, 64, smallest calibration span accepted; a narrower window falls back to the defaults.
- SMOOTH_SHIFT, 2, IIR coefficient 2^-SMOOTH_SHIFT; 0 bypasses the filter.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- adc_valid  in  1  one-cycle strobe: adc_data holds a complete frame.
- adc_data  in  CHANNELS*ADC_W  channel c at bits [c*ADC_W +: ADC_W].
- cal_lo  in  ADC_W  manual lower bound, used when auto_cal=0.
- cal_hi  in  ADC_W  manual upper bound, used when auto_cal=0.
- auto_cal  in  1  1 = use per-channel tracked min/max as the window.
- cal_clear  in  1  one-cycle pulse: reset the trackers and clear overrun.
- invert  in  CHANNELS  per-channel bitwise inversion of the output.
- paddle  out  CHANNELS*OUT_W  signed positions, same channel packing as adc_data.
- paddle_valid  out  1  one-cycle pulse when the whole frame has been updated.
- busy  out  1  high from frame capture until paddle_valid.
- overrun  out  1  sticky: a frame arrived while busy.

Behaviour:
- Clock and reset:
  - One clock (clk_sys).
  - Reset is synchronous and active-high.
- Reset values:
  - paddle = 0 (centre); paddle_valid, busy and overrun = 0.
  - Filter state = 0.
  - Tracker min = all ones, tracker max = 0.
  - FSM = IDLE.
- FSM states: IDLE, CLAMP, MUL, DIV, FILT, NEXT, DONE.
- IDLE:
  - On adc_valid, latch all of adc_data, set channel index c=0, set busy, go to CLAMP.
- CLAMP (1 cycle):
  - Select the window:
    - auto_cal=1: lo = trkmin[c], hi = trkmax[c];
    - auto_cal=0: lo = cal_lo, hi = cal_hi.
  - If hi <= lo or hi-lo < MIN_SPAN, use DEF_LO/DEF_HI instead.
  - x = min(max(sample, lo), hi).
  - When auto_cal=1, update trkmin/trkmax with the raw sample in this same cycle. The window for this sample is the one before the update.
- MUL (1 cycle):
  - num = (x-lo)*(2^OUT_W-1), width ADC_W+OUT_W.
  - den = hi-lo.
- DIV (OUT_W cycles):
  - Restoring division, one quotient bit per cycle, MSB first.
  - q in [0, 2^OUT_W-1], truncating.
- FILT (1 cycle):
  - t = q - 2^(OUT_W-1), signed OUT_W.
  - y = y + ((t - y) >>> SMOOTH_SHIFT), with arithmetic kept to OUT_W+1 bits so there is no overflow.
  - SMOOTH_SHIFT=0 gives y = t.
  - Write paddle[c] = invert[c] ? ~y : y.
- NEXT:
  - If c = CHANNELS-1, go to DONE; otherwise c++ and go to CLAMP.
- DONE:
  - paddle_valid=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - OUT_W+4 cycles per channel, plus 2 cycles of overhead.
  - With defaults: 4*12 + 2 = 50 cycles from adc_valid to paddle_valid.
- adc_valid while busy:
  - The frame is dropped and overrun is set.
  - The frame in flight completes unaffected.
- cal_clear:
  - Resets trkmin/trkmax and clears overrun.
  - If it coincides with a CLAMP tracker update, cal_clear wins; the current sample's window is unaffected.
- Output timing:
  - Outputs of channels not yet processed keep their previous frame value.
  - All channels are consistent at paddle_valid.
- Reset mid-frame aborts immediately and returns to reset values.

Decomposition:
- Package paddle_pkg:
  - state enum typedef;
  - DEF_LO/DEF_HI/MIN_SPAN defaults;
  - helper function for the window-selection and fallback rule.
- Sub-module paddle_serial_div:
  - parameters NUM_W, DEN_W, Q_W;
  - ports start, num, den, done, q;
  - fixed Q_W-cycle latency;
  - instantiated once and shared across channels.

Test Plan:
- Defaults (manual window 300/1500, SMOOTH_SHIFT=0), frame {300, 1500, 900, 100} -> paddle {0x80, 0x7F, 0xFF, 0x80}; paddle_valid exactly 50 cycles after adc_valid.
- Sample 4000 on ch1 -> 0x7F. Same with invert=4'b0010 -> 0x80.
- cal_lo=1000, cal_hi=1010 (span < MIN_SPAN), sample 900 -> 0xFF, i.e. default window used.
- SMOOTH_SHIFT=2, from reset, repeated frames with ch0=1500 -> ch0 sequence 31, 55, 73, 86.
- Second adc_valid 10 cycles after the first -> overrun=1, exactly one paddle_valid; cal_clear -> overrun=0.
- auto_cal=1, cal_clear, then frames ch0 = 200, 3000, 1600 -> third frame window 200/3000, output (1400*255/2800) - 128 = 127-128 = 0xFF. Reset asserted mid-DIV -> busy=0, paddle=0, no paddle_valid.

Source files
------------

// File: rtl/paddle_pkg.sv
// Shared types and defaults for the paddle ADC conditioner: FSM state encoding,
// calibration window defaults and the window validity rule.
package paddle_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLAMP = 3'd1,
        S_MUL   = 3'd2,
        S_DIV   = 3'd3,
        S_FILT  = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    localparam int unsigned DEFAULT_LO       = 32'd300;
    localparam int unsigned DEFAULT_HI       = 32'd1500;
    localparam int unsigned DEFAULT_MIN_SPAN = 32'd64;

    // A window is usable only if it is ordered and at least min_span wide.
    function automatic logic window_ok(input logic [31:0] lo, input logic [31:0] hi,
                                       input logic [31:0] min_span);
        logic ok;
        if (hi > lo) begin
            ok = ((hi - lo) >= min_span);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/paddle_adc_conditioner_div.sv
// Restoring serial divider: one quotient bit per cycle, MSB first, fixed Q_W-cycle
// latency. The caller guarantees num < den * 2^Q_W so the quotient fits Q_W bits.
module paddle_serial_div #(
    parameter int unsigned NUM_W = 20,
    parameter int unsigned DEN_W = 12,
    parameter int unsigned Q_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [Q_W-1:0]   q
);

    localparam int unsigned CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [DEN_W:0]   trial_s;
    logic [DEN_W:0]   diff_s;
    logic             ge_s;

    // Quotient register doubles as the shift register for the low dividend bits.
    always_comb begin
        trial_s  = {rem_q, quo_q[Q_W-1]};
        diff_s   = trial_s - {1'b0, den_q};
        ge_s     = (trial_s >= {1'b0, den_q});
        rem_d    = rem_q;
        den_d    = den_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            rem_d    = DEN_W'(num >> Q_W);
            den_d    = den;
            quo_d    = num[Q_W-1:0];
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            rem_d = ge_s ? diff_s[DEN_W-1:0] : trial_s[DEN_W-1:0];
            quo_d = {quo_q[Q_W-2:0], ge_s};
            if (cnt_q == CNT_W'(Q_W - 1)) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q    <= '0;
            den_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            den_q    <= den_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done = active_q && (cnt_q == CNT_W'(Q_W - 1));
    assign q    = quo_q;

endmodule

// File: rtl/paddle_adc_conditioner.sv
// Analog paddle front end: clamps each ADC channel to a calibration window, scales it
// to a signed position through a shared serial divider and IIR-smooths the result.
module paddle_adc_conditioner
    import paddle_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned ADC_W        = 12,
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned DEF_LO       = DEFAULT_LO,
    parameter int unsigned DEF_HI       = DEFAULT_HI,
    parameter int unsigned MIN_SPAN     = DEFAULT_MIN_SPAN,
    parameter int unsigned SMOOTH_SHIFT = 2
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      adc_valid,
    input  logic [CHANNELS*ADC_W-1:0] adc_data,
    input  logic [ADC_W-1:0]          cal_lo,
    input  logic [ADC_W-1:0]          cal_hi,
    input  logic                      auto_cal,
    input  logic                      cal_clear,
    input  logic [CHANNELS-1:0]       invert,
    output logic [CHANNELS*OUT_W-1:0] paddle,
    output logic                      paddle_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned NUM_W = ADC_W + OUT_W;
    localparam logic [NUM_W-1:0] SCALE   = NUM_W'((2 ** OUT_W) - 1);
    localparam logic [ADC_W-1:0] LO_DEF  = ADC_W'(DEF_LO);
    localparam logic [ADC_W-1:0] HI_DEF  = ADC_W'(DEF_HI);
    localparam logic [CW-1:0]    LAST_CH = CW'(CHANNELS - 1);

    state_e                             state_q, state_d;
    logic [CW-1:0]                      c_q, c_d;
    logic [CHANNELS-1:0][ADC_W-1:0]     sample_q, sample_d;
    logic [CHANNELS-1:0][ADC_W-1:0]     trkmin_q, trkmin_d;
    logic [CHANNELS-1:0][ADC_W-1:0]     trkmax_q, trkmax_d;
    logic [CHANNELS-1:0][OUT_W-1:0]     y_q, y_d;
    logic [CHANNELS-1:0][OUT_W-1:0]     paddle_q, paddle_d;
    logic [ADC_W-1:0]                   lo_q, lo_d, hi_q, hi_d, x_q, x_d;
    logic                               paddle_valid_q, paddle_valid_d;
    logic                               busy_q, busy_d;
    logic                               overrun_q, overrun_d;

    logic [ADC_W-1:0]   cur_s, raw_lo_s, raw_hi_s, win_lo_s, win_hi_s, x_s;
    logic [NUM_W-1:0]   num_s;
    logic [ADC_W-1:0]   den_s;
    logic               div_start_s, div_done_s;
    logic [OUT_W-1:0]   q_s, y_new_s;
    logic signed [OUT_W:0] t_ext_s, y_ext_s, diff_s, step_s, sum_s;

    // Window selection, fallback and clamp for the channel being processed.
    always_comb begin
        cur_s = sample_q[c_q];
        if (auto_cal) begin
            raw_lo_s = trkmin_q[c_q];
            raw_hi_s = trkmax_q[c_q];
        end else begin
            raw_lo_s = cal_lo;
            raw_hi_s = cal_hi;
        end
        if (window_ok(32'(raw_lo_s), 32'(raw_hi_s), MIN_SPAN)) begin
            win_lo_s = raw_lo_s;
            win_hi_s = raw_hi_s;
        end else begin
            win_lo_s = LO_DEF;
            win_hi_s = HI_DEF;
        end
        if (cur_s < win_lo_s) begin
            x_s = win_lo_s;
        end else if (cur_s > win_hi_s) begin
            x_s = win_hi_s;
        end else begin
            x_s = cur_s;
        end
    end

    // Scaling operands and IIR step; the filter runs one bit wider so t - y cannot wrap.
    always_comb begin
        num_s   = NUM_W'(x_q - lo_q) * SCALE;
        den_s   = hi_q - lo_q;
        t_ext_s = {~q_s[OUT_W-1], ~q_s[OUT_W-1], q_s[OUT_W-2:0]};
        y_ext_s = {y_q[c_q][OUT_W-1], y_q[c_q]};
        diff_s  = t_ext_s - y_ext_s;
        step_s  = diff_s >>> SMOOTH_SHIFT;
        sum_s   = y_ext_s + step_s;
        y_new_s = sum_s[OUT_W-1:0];
    end

    paddle_serial_div #(
        .NUM_W (NUM_W),
        .DEN_W (ADC_W),
        .Q_W   (OUT_W)
    ) u_div (
        .clk   (clk_sys),
        .reset (reset),
        .start (div_start_s),
        .num   (num_s),
        .den   (den_s),
        .done  (div_done_s),
        .q     (q_s)
    );

    // Frame sequencer: next state and all register updates.
    always_comb begin
        state_d        = state_q;
        c_d            = c_q;
        sample_d       = sample_q;
        trkmin_d       = trkmin_q;
        trkmax_d       = trkmax_q;
        y_d            = y_q;
        paddle_d       = paddle_q;
        lo_d           = lo_q;
        hi_d           = hi_q;
        x_d            = x_q;
        paddle_valid_d = 1'b0;
        busy_d         = busy_q;
        overrun_d      = overrun_q;
        div_start_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (adc_valid) begin
                    sample_d = adc_data;
                    c_d      = '0;
                    busy_d   = 1'b1;
                    state_d  = S_CLAMP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLAMP: begin
                lo_d = win_lo_s;
                hi_d = win_hi_s;
                x_d  = x_s;
                if (auto_cal) begin
                    if (cur_s < trkmin_q[c_q]) begin
                        trkmin_d[c_q] = cur_s;
                    end else begin
                        trkmin_d[c_q] = trkmin_q[c_q];
                    end
                    if (cur_s > trkmax_q[c_q]) begin
                        trkmax_d[c_q] = cur_s;
                    end else begin
                        trkmax_d[c_q] = trkmax_q[c_q];
                    end
                end else begin
                    trkmin_d = trkmin_q;
                end
                state_d = S_MUL;
            end
            S_MUL: begin
                div_start_s = 1'b1;
                state_d     = S_DIV;
            end
            S_DIV: begin
                if (div_done_s) begin
                    state_d = S_FILT;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_FILT: begin
                y_d[c_q]      = y_new_s;
                paddle_d[c_q] = invert[c_q] ? ~y_new_s : y_new_s;
                state_d       = S_NEXT;
            end
            S_NEXT: begin
                if (c_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    c_d     = c_q + CW'(1);
                    state_d = S_CLAMP;
                end
            end
            S_DONE: begin
                paddle_valid_d = 1'b1;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // cal_clear takes priority over any tracker update and over a new overrun.
        if (cal_clear) begin
            trkmin_d  = '1;
            trkmax_d  = '0;
            overrun_d = 1'b0;
        end else if (adc_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= S_IDLE;
            c_q            <= '0;
            sample_q       <= '0;
            trkmin_q       <= '1;
            trkmax_q       <= '0;
            y_q            <= '0;
            paddle_q       <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            x_q            <= '0;
            paddle_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            c_q            <= c_d;
            sample_q       <= sample_d;
            trkmin_q       <= trkmin_d;
            trkmax_q       <= trkmax_d;
            y_q            <= y_d;
            paddle_q       <= paddle_d;
            lo_q           <= lo_d;
            hi_q           <= hi_d;
            x_q            <= x_d;
            paddle_valid_q <= paddle_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    assign paddle       = paddle_q;
    assign paddle_valid = paddle_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_paddle_adc_conditioner.sv
// Randomized self-checking bench: two conditioners (unfiltered and SMOOTH_SHIFT=2) share
// stimulus and are compared against an arithmetic frame model.
module tb_paddle_adc_conditioner;

    logic        clk_sys = 1'b0;
    logic        reset, adc_valid, auto_cal, cal_clear;
    logic [47:0] adc_data;
    logic [11:0] cal_lo, cal_hi;
    logic [3:0]  invert;
    logic [31:0] p0, p2;
    logic        pv0, pv2, b0, b2, o0, o2;

    int n_tests = 0;
    int n_fail  = 0;
    int m_y0[4], m_y2[4], m_tmin[4], m_tmax[4], e0[4], e2[4];

    always #5 clk_sys = ~clk_sys;

    paddle_adc_conditioner #(.SMOOTH_SHIFT(0)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
        .cal_lo(cal_lo), .cal_hi(cal_hi), .auto_cal(auto_cal), .cal_clear(cal_clear),
        .invert(invert), .paddle(p0), .paddle_valid(pv0), .busy(b0), .overrun(o0));

    paddle_adc_conditioner #(.SMOOTH_SHIFT(2)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
        .cal_lo(cal_lo), .cal_hi(cal_hi), .auto_cal(auto_cal), .cal_clear(cal_clear),
        .invert(invert), .paddle(p2), .paddle_valid(pv2), .busy(b2), .overrun(o2));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_tmin[c] = 4095;
            m_tmax[c] = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        for (int c = 0; c < 4; c++) begin
            m_y0[c] = 0;
            m_y2[c] = 0;
        end
    endtask

    // Expected outputs of one frame, computed from the window/scale/filter rules.
    task automatic model_frame(input logic [47:0] d);
        int s, lo, hi, x, q, t;
        for (int c = 0; c < 4; c++) begin
            s = int'(d[c*12 +: 12]);
            if (auto_cal) begin
                lo = m_tmin[c];
                hi = m_tmax[c];
            end else begin
                lo = int'(cal_lo);
                hi = int'(cal_hi);
            end
            if (hi <= lo || hi - lo < 64) begin
                lo = 300;
                hi = 1500;
            end
            x = (s < lo) ? lo : ((s > hi) ? hi : s);
            q = ((x - lo) * 255) / (hi - lo);
            t = q - 128;
            m_y0[c] = t;
            m_y2[c] = m_y2[c] + ((t - m_y2[c]) >>> 2);
            e0[c] = invert[c] ? ((~m_y0[c]) & 255) : (m_y0[c] & 255);
            e2[c] = invert[c] ? ((~m_y2[c]) & 255) : (m_y2[c] & 255);
            if (auto_cal) begin
                if (s < m_tmin[c]) m_tmin[c] = s;
                if (s > m_tmax[c]) m_tmax[c] = s;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_clear();
        cal_clear = 1'b1;
        @(posedge clk_sys);
        #1 cal_clear = 1'b0;
        model_clear();
    endtask

    task automatic run_frame(input string tag, input logic [47:0] d);
        int lat;
        model_frame(d);
        adc_data  = d;
        adc_valid = 1'b1;
        @(posedge clk_sys);
        #1 adc_valid = 1'b0;
        check_val($sformatf("%s_busy", tag), 32'({b2, b0}), 32'd3);
        lat = 1;
        while (!pv0 && lat < 200) begin
            @(posedge clk_sys);
            #1 lat++;
        end
        check_val($sformatf("%s_latency", tag), lat, 32'd50);
        check_val($sformatf("%s_pv2", tag), 32'(pv2), 32'd1);
        check_val($sformatf("%s_busy_done", tag), 32'({b2, b0}), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("%s_s0_ch%0d", tag, c), 32'(p0[c*8 +: 8]), e0[c]);
            check_val($sformatf("%s_s2_ch%0d", tag, c), 32'(p2[c*8 +: 8]), e2[c]);
        end
        @(posedge clk_sys);
        #1 check_val($sformatf("%s_pv_pulse", tag), 32'({pv2, pv0}), 32'd0);
    endtask

    initial begin
        logic [47:0] d;
        logic [31:0] snap0, snap2;
        int npv, lo, r;
        int seq[4];
        seq[0] = 31; seq[1] = 55; seq[2] = 73; seq[3] = 86;
        reset = 1'b1; adc_valid = 1'b0; auto_cal = 1'b0; cal_clear = 1'b0;
        adc_data = '0; cal_lo = 12'd300; cal_hi = 12'd1500; invert = 4'b0000;
        do_reset();
        check_val("rst_paddle", p0 | p2, 32'd0);
        check_val("rst_flags", 32'({pv0, pv2, b0, b2, o0, o2}), 32'd0);

        // Filter step response from reset.
        for (int k = 0; k < 4; k++) begin
            run_frame($sformatf("smooth%0d", k), {12'd900, 12'd900, 12'd900, 12'd1500});
            check_val($sformatf("smooth_seq%0d", k), 32'(p2[7:0]), seq[k]);
        end

        run_frame("dir_base", {12'd100, 12'd900, 12'd1500, 12'd300});
        check_val("dir_base_const", p0, 32'h80FF7F80);
        run_frame("dir_over", {12'd900, 12'd1500, 12'd4000, 12'd300});
        check_val("dir_over_const", 32'(p0[15:8]), 32'h7F);
        invert = 4'b0010;
        run_frame("dir_inv", {12'd900, 12'd1500, 12'd4000, 12'd300});
        check_val("dir_inv_const", 32'(p0[15:8]), 32'h80);
        invert = 4'b0000;
        cal_lo = 12'd1000; cal_hi = 12'd1010;
        run_frame("dir_narrow", {12'd1005, 12'd900, 12'd1010, 12'd1000});
        check_val("dir_narrow_const", 32'(p0[23:16]), 32'hFF);
        cal_lo = 12'd300; cal_hi = 12'd1500;

        // Overrun: second frame 10 cycles into the first is dropped.
        d = {12'd1200, 12'd700, 12'd50, 12'd3333};
        model_frame(d);
        adc_data = d; adc_valid = 1'b1;
        @(posedge clk_sys);
        #1 adc_valid = 1'b0;
        npv = 0; snap0 = '0; snap2 = '0;
        for (int i = 1; i < 120; i++) begin
            if (i == 10) begin
                adc_data = 48'h123456789ABC; adc_valid = 1'b1;
            end else begin
                adc_valid = 1'b0;
            end
            @(posedge clk_sys);
            #1 if (pv0) begin
                npv++; snap0 = p0; snap2 = p2;
            end
        end
        check_val("ovr_pv_count", npv, 32'd1);
        check_val("ovr_flag", 32'({o2, o0}), 32'd3);
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("ovr_s0_ch%0d", c), 32'(snap0[c*8 +: 8]), e0[c]);
            check_val($sformatf("ovr_s2_ch%0d", c), 32'(snap2[c*8 +: 8]), e2[c]);
        end
        pulse_clear();
        check_val("ovr_cleared", 32'({o2, o0}), 32'd0);

        // Auto-tracked window.
        auto_cal = 1'b1;
        pulse_clear();
        run_frame("auto0", {12'd500, 12'd500, 12'd500, 12'd200});
        run_frame("auto1", {12'd2500, 12'd2500, 12'd2500, 12'd3000});
        run_frame("auto2", {12'd1000, 12'd1000, 12'd1000, 12'd1600});
        check_val("auto2_const", 32'(p0[7:0]), 32'hFF);

        // Randomized frames and calibration settings.
        for (int k = 0; k < 16; k++) begin
            auto_cal = 1'($urandom_range(0, 1));
            invert   = 4'($urandom);
            lo = $urandom_range(0, 2000);
            r  = $urandom_range(0, 2);
            cal_lo = 12'(lo);
            if (r == 0) cal_hi = 12'(lo + $urandom_range(64, 2000));
            else if (r == 1) cal_hi = 12'(lo + $urandom_range(0, 63));
            else cal_hi = 12'($urandom_range(0, lo));
            if ($urandom_range(0, 3) == 0) pulse_clear();
            d = {12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom)};
            run_frame($sformatf("rnd%0d", k), d);
        end

        // Reset in the middle of the first channel's division.
        adc_data = 48'hABCDEF012345; adc_valid = 1'b1;
        @(posedge clk_sys);
        #1 adc_valid = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1 check_val("midrst_busy_before", 32'({b2, b0}), 32'd3);
        reset = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        model_reset();
        check_val("midrst_paddle", p0 | p2, 32'd0);
        check_val("midrst_flags", 32'({pv0, pv2, b0, b2, o0, o2}), 32'd0);
        npv = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_sys);
            #1 if (pv0 || pv2) npv++;
        end
        check_val("midrst_no_pv", npv, 32'd0);
        auto_cal = 1'b0; invert = 4'b0101; cal_lo = 12'd300; cal_hi = 12'd1500;
        run_frame("post_rst", {12'd1400, 12'd800, 12'd0, 12'd4095});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
